regfile_port_ctrl: RTL

Sequencing master for the 8x16 LC-3b register file write/read port: it owns the source-address, destination-address, data and load-enable signals of the register file and services block commands from a debug/boot host. It supports three operations: dump a range of registers out on a valid/ready stream, load a range from a valid/ready stream, and clear a range to zero. It sits between the host link and the register file, replacing hand-driven address and load-enable strobes during boot and debug.

---
 rtl/regfile_port_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/regfile_port_ctrl.sv
// Block-command sequencer for the 8x16 register-file port: dumps a register range
// onto a valid/ready stream, loads a range from a stream, or clears a range to zero.
module regfile_port_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_count,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_sr1,
  input  logic [DATA_W-1:0] rf_sr1_out,
  output logic [ADDR_W-1:0] rf_dr,
  output logic [DATA_W-1:0] rf_in,
  output logic              rf_ldreg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DUMP  = 2'd1,
    LOAD  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam logic [1:0]        OP_DUMP  = 2'b00;
  localparam logic [1:0]        OP_LOAD  = 2'b01;
  localparam logic [1:0]        OP_CLEAR = 2'b10;
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   ptr, ptr_next;
  logic [ADDR_W:0]     remaining, remaining_next;
  logic [DATA_W-1:0]   rd_data_next;
  logic                rd_valid_next;
  logic                capture;
  logic                beat_done;

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    remaining_next = remaining;
    rd_data_next   = rd_data;
    rd_valid_next  = rd_valid;
    cmd_ready      = 1'b0;
    busy           = 1'b1;
    wr_ready       = 1'b0;
    rf_sr1         = '0;
    rf_dr          = '0;
    rf_in          = '0;
    rf_ldreg       = 1'b0;
    capture        = (remaining != '0) && (!rd_valid || rd_ready);
    beat_done      = rd_valid && rd_ready;

    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid && cmd_op != 2'b11) begin
          ptr_next       = cmd_base;
          remaining_next = {1'b0, cmd_count} + REM_ONE;
          unique case (cmd_op)
            OP_DUMP:  state_next = DUMP;
            OP_LOAD:  state_next = LOAD;
            OP_CLEAR: state_next = CLEAR;
            default:  state_next = IDLE;
          endcase
        end
      end

      DUMP: begin
        rf_sr1 = ptr;
        if (capture) begin
          rd_data_next   = rf_sr1_out;
          rd_valid_next  = 1'b1;
          ptr_next       = ptr + PTR_ONE;
          remaining_next = remaining - REM_ONE;
        end else if (beat_done) begin
          rd_valid_next = 1'b0;
        end
        // The last word has been captured and now leaves on this handshake.
        if (remaining == '0 && beat_done) begin
          state_next = IDLE;
        end
      end

      LOAD: begin
        wr_ready = 1'b1;
        rf_dr    = ptr;
        rf_in    = wr_data;
        rf_ldreg = wr_valid;
        if (wr_valid) begin
          ptr_next       = ptr + PTR_ONE;
          remaining_next = remaining - REM_ONE;
          if (remaining == REM_ONE) state_next = IDLE;
        end
      end

      CLEAR: begin
        rf_dr          = ptr;
        rf_ldreg       = 1'b1;
        ptr_next       = ptr + PTR_ONE;
        remaining_next = remaining - REM_ONE;
        if (remaining == REM_ONE) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      remaining <= remaining_next;
      rd_data   <= rd_data_next;
      rd_valid  <= rd_valid_next;
    end
  end

endmodule
